// File: rtl/kernel_control_pkg.sv
// Shared types and default geometry for the 3x3 kernel-window generator.
// Widths here describe the default build; the top derives its own from its parameters.
package kernel_control_pkg;

  localparam int DEF_LINE_LENGTH = 48;
  localparam int DEF_LINE_COUNT  = 48;
  localparam int DEF_DATA_WIDTH  = 16;

  localparam int X_WIDTH = $clog2(DEF_LINE_LENGTH);
  localparam int Y_WIDTH = $clog2(DEF_LINE_COUNT);

  typedef logic [DEF_DATA_WIDTH-1:0]   pixel_t;
  typedef logic [3*DEF_DATA_WIDTH-1:0] row_t;
  typedef logic [1:0]                  buf_sel_t;

  // Line-buffer roles rotate 0 -> 1 -> 2 -> 0 at every line end.
  function automatic buf_sel_t rot_next(input buf_sel_t sel);
    return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
  endfunction

endpackage

// File: rtl/kernel_line_buffer.sv
// One line of pixel storage: synchronous write, combinational read.
module kernel_line_buffer #(
  parameter int DEPTH = 48,
  parameter int WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/kernel_control.sv
// Streaming 3x3 window generator: buffers two previous lines and emits a registered
// window (r0 = y-2 ... r2 = y) for every accepted pixel with x >= 2 and y >= 2.
module kernel_control
  import kernel_control_pkg::*;
#(
  parameter int LINE_LENGTH = DEF_LINE_LENGTH,
  parameter int LINE_COUNT  = DEF_LINE_COUNT,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_valid,
  output logic                    o_req,
  output logic [3*DATA_WIDTH-1:0] o_r0_data,
  output logic [3*DATA_WIDTH-1:0] o_r1_data,
  output logic [3*DATA_WIDTH-1:0] o_r2_data,
  output logic                    o_valid
);

  localparam int XW = $clog2(LINE_LENGTH);
  localparam int YW = $clog2(LINE_COUNT);
  localparam int RW = 3 * DATA_WIDTH;

  localparam logic [XW-1:0] X_LAST  = XW'(LINE_LENGTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(LINE_COUNT - 1);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [XW-1:0] X_FIRST = XW'(2);
  localparam logic [YW-1:0] Y_FIRST = YW'(2);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  buf_sel_t      rot_q, rot_d;
  logic          req_q, req_d;
  logic          valid_q, valid_d;
  logic [RW-1:0] sr0_q, sr0_d, sr1_q, sr1_d, sr2_q, sr2_d;
  logic [RW-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_data [3];
  logic [DATA_WIDTH-1:0] prev1_pix, prev2_pix;

  assign accept = i_valid && req_q;

  for (genvar g = 0; g < 3; g++) begin : g_buf
    kernel_line_buffer #(
      .DEPTH(LINE_LENGTH),
      .WIDTH(DATA_WIDTH)
    ) u_buf (
      .i_clk  (i_clk),
      .i_we   (accept && (rot_q == buf_sel_t'(g))),
      .i_waddr(x_q),
      .i_wdata(i_data),
      .i_raddr(x_q),
      .o_rdata(rd_data[g])
    );
  end

  // Buffer rot_q holds line y; the one before it in rotation holds y-1, the one after y-2.
  always_comb begin
    prev1_pix = rd_data[2];
    prev2_pix = rd_data[1];
    case (rot_q)
      2'd1: begin
        prev1_pix = rd_data[0];
        prev2_pix = rd_data[2];
      end
      2'd2: begin
        prev1_pix = rd_data[1];
        prev2_pix = rd_data[0];
      end
      default: begin
        prev1_pix = rd_data[2];
        prev2_pix = rd_data[1];
      end
    endcase
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    rot_d   = rot_q;
    req_d   = 1'b1;
    valid_d = 1'b0;
    sr0_d   = sr0_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;

    if (accept) begin
      sr0_d = {sr0_q[2*DATA_WIDTH-1:0], prev2_pix};
      sr1_d = {sr1_q[2*DATA_WIDTH-1:0], prev1_pix};
      sr2_d = {sr2_q[2*DATA_WIDTH-1:0], i_data};

      if (x_q == X_LAST) begin
        x_d   = '0;
        rot_d = rot_next(rot_q);
        y_d   = (y_q == Y_LAST) ? '0 : y_q + Y_ONE;
      end else begin
        x_d = x_q + X_ONE;
      end

      // Shift registers hold stale columns for x < 2, so only full windows are published.
      if ((y_q >= Y_FIRST) && (x_q >= X_FIRST)) begin
        valid_d = 1'b1;
        r0_d    = sr0_d;
        r1_d    = sr1_d;
        r2_d    = sr2_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      x_q     <= '0;
      y_q     <= '0;
      rot_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      sr0_q   <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      rot_q   <= rot_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      sr0_q   <= sr0_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
    end
  end

  assign o_req     = req_q;
  assign o_valid   = valid_q;
  assign o_r0_data = r0_q;
  assign o_r1_data = r1_q;
  assign o_r2_data = r2_q;

endmodule

// File: tb/tb_kernel_control.sv
// Directed bench for kernel_control: pixel value = y*48+x, every cycle checked against
// a small raster model, plus frame-level window counts and literal corner values.
module tb_kernel_control;
  import kernel_control_pkg::*;

  localparam int LL   = 48;
  localparam int LC   = 48;
  localparam int WINS = (LC - 2) * (LL - 2);

  logic   i_clk = 1'b0;
  logic   i_rstn;
  logic   i_valid;
  pixel_t i_data;
  logic   o_req;
  logic   o_valid;
  row_t   o_r0_data, o_r1_data, o_r2_data;

  always #5 i_clk = ~i_clk;

  kernel_control #(
    .LINE_LENGTH(LL),
    .LINE_COUNT (LC),
    .DATA_WIDTH (16)
  ) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_req    (o_req),
    .o_r0_data(o_r0_data),
    .o_r1_data(o_r1_data),
    .o_r2_data(o_r2_data),
    .o_valid  (o_valid)
  );

  typedef struct {
    logic   valid;
    pixel_t data;
    int     y;
    int     x;
    logic   exp_valid;
    row_t   r0;
    row_t   r1;
    row_t   r2;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cur_x, cur_y;
  logic exp_req;
  row_t hold0, hold1, hold2;
  int   win_seen;
  row_t last_r2_seen;
  vec_t tbl[$];
  vec_t v;

  function automatic pixel_t pix(input int y, input int x);
    return pixel_t'(y * LL + x);
  endfunction

  function automatic row_t rowAt(input int y, input int x);
    return {pix(y, x - 2), pix(y, x - 1), pix(y, x)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advances the raster model by one cycle and returns the vector to drive.
  task automatic buildVec(input logic valid, output vec_t vo);
    vo.valid     = valid;
    vo.exp_valid = 1'b0;
    vo.y         = -1;
    vo.x         = -1;
    vo.data      = pixel_t'($urandom);
    if (valid && exp_req) begin
      vo.y    = cur_y;
      vo.x    = cur_x;
      vo.data = pix(cur_y, cur_x);
      if (cur_y >= 2 && cur_x >= 2) begin
        vo.exp_valid = 1'b1;
        hold0 = rowAt(cur_y - 2, cur_x);
        hold1 = rowAt(cur_y - 1, cur_x);
        hold2 = rowAt(cur_y, cur_x);
      end
      if (cur_x == LL - 1) begin
        cur_x = 0;
        cur_y = (cur_y == LC - 1) ? 0 : cur_y + 1;
      end else begin
        cur_x++;
      end
    end
    vo.r0   = hold0;
    vo.r1   = hold1;
    vo.r2   = hold2;
    exp_req = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t vi);
    i_valid = vi.valid;
    i_data  = vi.data;
    @(posedge i_clk);
    #1;
    checkOutput($sformatf("o_req y%0d x%0d", vi.y, vi.x), o_req, 1);
    checkOutput($sformatf("o_valid y%0d x%0d", vi.y, vi.x), o_valid, vi.exp_valid);
    checkOutput($sformatf("o_r0 y%0d x%0d", vi.y, vi.x), o_r0_data, vi.r0);
    checkOutput($sformatf("o_r1 y%0d x%0d", vi.y, vi.x), o_r1_data, vi.r1);
    checkOutput($sformatf("o_r2 y%0d x%0d", vi.y, vi.x), o_r2_data, vi.r2);
    if (o_valid) begin
      win_seen++;
      last_r2_seen = o_r2_data;
    end
  endtask

  task automatic doReset(input int cycles);
    i_rstn  = 1'b1;
    i_valid = 1'b1;
    i_data  = pixel_t'($urandom);
    repeat (cycles) @(posedge i_clk);
    #1;
    checkOutput("reset o_req", o_req, 0);
    checkOutput("reset o_valid", o_valid, 0);
    checkOutput("reset o_r0", o_r0_data, 0);
    checkOutput("reset o_r1", o_r1_data, 0);
    checkOutput("reset o_r2", o_r2_data, 0);
    i_rstn  = 1'b0;
    cur_x   = 0;
    cur_y   = 0;
    exp_req = 1'b0;
    hold0   = '0;
    hold1   = '0;
    hold2   = '0;
    // Pixel offered on the release edge must be ignored since o_req is still low.
    buildVec(1'b1, v);
    applyStimulus(v);
  endtask

  task automatic runFrame(input int duty_pct, input int stop_y, input int stop_x);
    vec_t fv;
    int   budget;
    budget = 4 * LL * LC;
    while (budget > 0) begin
      if (cur_y == stop_y && cur_x == stop_x) break;
      buildVec($urandom_range(99) < duty_pct, fv);
      applyStimulus(fv);
      if (fv.y == LC - 1 && fv.x == LL - 1) break;
      budget--;
    end
    if (budget == 0) checkOutput("frame cycle budget", 1, 0);
  endtask

  task automatic endFrameCheck(input string name);
    checkOutput({name, " window count"}, 64'(win_seen), 64'(WINS));
    // Last window sits at row 47, columns 45..47: 47*48+45 = 2301.
    checkOutput({name, " last r2"}, last_r2_seen, {16'd2301, 16'd2302, 16'd2303});
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rstn  = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    exp_req = 1'b0;
    hold0   = '0;
    hold1   = '0;
    hold2   = '0;
    last_r2_seen = '0;

    doReset(25);
    win_seen = 0;

    // Rows 0..3 of the first frame with an idle cycle in every fifth slot.
    for (int i = 0; cur_y < 4; i++) begin
      buildVec((i % 5) != 4, v);
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      if (tbl[i].y == 2 && tbl[i].x == 2) begin
        checkOutput("first window count", 64'(win_seen), 1);
        checkOutput("first r0", o_r0_data, {16'd0, 16'd1, 16'd2});
        checkOutput("first r1", o_r1_data, {16'd48, 16'd49, 16'd50});
        checkOutput("first r2", o_r2_data, {16'd96, 16'd97, 16'd98});
      end
      if (tbl[i].y == 2 && tbl[i].x == 47) begin
        checkOutput("line end r0", o_r0_data, {16'd45, 16'd46, 16'd47});
      end
      if (tbl[i].y == 3 && tbl[i].x < 2) begin
        checkOutput($sformatf("row3 col%0d no window", tbl[i].x), o_valid, 0);
      end
      if (tbl[i].y == 3 && tbl[i].x == 2) begin
        checkOutput("row3 r0", o_r0_data, {16'd48, 16'd49, 16'd50});
        checkOutput("row3 r2", o_r2_data, {16'd144, 16'd145, 16'd146});
      end
    end

    runFrame(100, -1, -1);
    endFrameCheck("frame1");

    win_seen = 0;
    runFrame(100, -1, -1);
    endFrameCheck("frame2");

    win_seen = 0;
    runFrame(50, -1, -1);
    endFrameCheck("gapped");

    runFrame(100, 10, 20);
    doReset(3);
    win_seen = 0;
    runFrame(100, -1, -1);
    endFrameCheck("after abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
